requant_mul_pipe: RTL
=====================

# requant_mul_pipe

Multi-lane, parametrised requantisation pipeline computing bit-exact TFLite `MultiplyByQuantizedMultiplier(x, multiplier, shift)` for both positive (left) and negative (right) shifts. Supports per-tensor or per-channel multiplier/shift, valid/ready backpressure, and optional output zero-point plus activation clamp. Sits between the accumulator output of the MAC array and the activation/writeback path, and supersedes the fixed right-shift-only, single-lane requant stage.

## Interface
- `LANES`, 4, parallel 32-bit lanes per beat.
- `PER_CHANNEL`, 0. 0: one multiplier/shift shared by all lanes. 1: one multiplier/shift per lane.
- `MUL_STAGES`, 2, register stages inside the 32x32 signed multiplier (≥1).
- `NQ`, derived: `PER_CHANNEL ? LANES : 1`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid & in_ready`.
- `in_data`  in  `LANES*32`  signed int32 per lane; lane i is `[32i+31:32i]`.
- `multiplier`  in  `NQ*32`  signed Q31 multiplier(s).
- `shift`  in  `NQ*8`  signed shift(s), legal range −31..+30.
- `out_zero_point`  in  32  signed, added after scaling.
- `act_min`  in  32  signed clamp low bound.
- `act_max`  in  32  signed clamp high bound.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  `LANES*32`  signed int32 per lane.

## Operation
- All side inputs (`multiplier`, `shift`, `out_zero_point`, `act_min`, `act_max`) are sampled with `in_data` on accept and travel with the beat. Parameters may change every beat.
- Per lane, with q/s the lane's (or the shared) multiplier/shift:
  - `ls = s>0 ? s : 0`; `rs = s>0 ? 0 : −s`.
  - `xs = x << ls`, 32-bit wrapping.
  - `ab = xs * q`, 64-bit signed.
  - SRDHM: if `xs == q == 0x80000000`, then `h = 0x7FFFFFFF`. Otherwise `h = (ab + (ab≥0 ? 2^30 : 1−2^30)) / 2^31`, with division truncating toward zero.
  - RDBPOT: `mask = 2^rs − 1`, `rem = h & mask`, `thr = (mask>>1) + (h<0)`, `r = (h >>> rs) + (rem > thr)`.
  - Output stage: see Configuration.
- Stage plan:
  - S0: register input and compute `xs`, `rs`.
  - S1..S`MUL_STAGES`: multiply.
  - Next stage: SRDHM.
  - Next stage: RDBPOT.
  - Final stage: output register.
- Global stall: `stall = out_valid & ~out_ready`. `in_ready = ~stall`, combinational. While stalled, every stage, including valids and side data, holds.
- No bubble collapsing. Empty stages advance normally when not stalled.

## Timing
- Latency: a beat accepted at edge N appears with `out_valid=1` after edge `N + MUL_STAGES + 3`. That is `MUL_STAGES+3` cycles, 5 at default, measured with `out_ready=1`.
- Throughput: one beat per cycle when `out_ready=1`.
- `out_valid`/`out_data` are stable while `out_valid & ~out_ready`.
- Reset (`rst=0` at an edge):
  - All stage valids, `out_valid`, and `out_data` go to 0.
  - In-flight beats are discarded, including on reset mid-stream or mid-stall.
  - `in_ready` reads 1 during and after reset.
- Simultaneous `in_valid` and stall: not accepted. The upstream holds the beat.
- Out-of-range `shift` is undefined; the bench does not drive it.

## Configuration
- Macro `REQUANT_ZP_CLAMP_EN`.
- Defined: `o = sat32(r + out_zero_point)`, then clamped to `[act_min, act_max]`. `sat32` is saturating 32-bit add. `act_min ≤ act_max` is required.
- Undefined: `o = r`. `out_zero_point`, `act_min`, `act_max` remain as ports and are ignored.
- Latency is identical in both builds.

## Test plan
- Half scale: x=100, q=2^30, s=0, zp=0, min=−2^31, max=2^31−1 → 50 on all lanes, exactly `MUL_STAGES+3` cycles after accept.
- Right shift, negative input: x=−100, q=2^30, s=−1 → −25. Also x=0x7FFFFFFF, q=0x7FFFFFFF, s=−31 → 1. Check RDBPOT rounding against a C model over 10k random beats.
- Left shift and per-channel (`PER_CHANNEL=1`): lanes x=3, s={2,1,0,−1}, q=2^30 → {6,3,2,1}.
- Overflow and clamp (`REQUANT_ZP_CLAMP_EN`):
  - x=q=0x80000000, s=0, max=127 → 127.
  - x=1000, q=2^30, zp=−128, min=−128, max=127 → 127.
  - x=−1000 → −128.
- Backpressure: stream 20 beats and toggle `out_ready` pseudo-randomly. Require no loss, no duplication, in-order output, and `out_data` stable while stalled.
- Reset mid-stream: assert `rst=0` for 1 cycle with 3 beats in flight and `out_ready=0`. Require `out_valid=0` the next cycle, no stale beat ever emitted, and a fresh beat afterwards at nominal latency.

Source files
------------

// File: rtl/requant_mul_pipe_if.sv
// Stream bus for requant_mul_pipe: input beat with its per-beat side data,
// and the output beat. The DUT uses the slave view, the producer/consumer
// side uses the master view. NQ must be PER_CHANNEL ? LANES : 1.
interface requant_mul_pipe_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned NQ    = 1
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*32-1:0]     in_data;
    logic [NQ*32-1:0]        multiplier;
    logic [NQ*8-1:0]         shift;
    logic [31:0]             out_zero_point;
    logic [31:0]             act_min;
    logic [31:0]             act_max;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*32-1:0]     out_data;

    modport master (
        output in_valid, in_data, multiplier, shift, out_zero_point, act_min, act_max,
        output out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, multiplier, shift, out_zero_point, act_min, act_max,
        input  out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/requant_mul_pipe.sv
// Multi-lane requantisation pipeline: bit-exact MultiplyByQuantizedMultiplier
// (left/right shift, SRDHM, RDBPOT) with a global valid/ready stall.
// Optional output zero-point + activation clamp: define REQUANT_ZP_CLAMP_EN.
// Stages: S0 | MUL_STAGES multiply | SRDHM | RDBPOT | output register.
module requant_mul_pipe #(
    parameter int unsigned LANES       = 4,
    parameter int unsigned PER_CHANNEL = 0,
    parameter int unsigned MUL_STAGES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    requant_mul_pipe_if.slave  bus
);
    localparam int unsigned NSTG = MUL_STAGES + 4;

    localparam logic signed [31:0] MIN32     = 32'sh8000_0000;
    localparam logic signed [31:0] MAX32     = 32'sh7FFF_FFFF;
    localparam logic signed [63:0] NUDGE_POS = 64'sh0000_0000_4000_0000;
    localparam logic signed [63:0] NUDGE_NEG = 64'shFFFF_FFFF_C000_0001;

    logic            w_stall;
    logic            w_adv;
    logic [NSTG-1:0] r_vld;
    logic [LANES-1:0][31:0] w_out_lanes;

    assign w_stall       = bus.out_valid & ~bus.out_ready;
    assign w_adv         = ~w_stall;
    // Ready is forced high while reset is asserted: anything taken then is flushed.
    assign bus.in_ready  = ~w_stall | ~rst;
    assign bus.out_valid = r_vld[NSTG-1];
    assign bus.out_data  = w_out_lanes;

    // Stage valid shift register; no bubble collapsing, whole pipe freezes on stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld <= '0;
        end else if (w_adv) begin
            r_vld <= {r_vld[NSTG-2:0], bus.in_valid};
        end
    end

`ifdef REQUANT_ZP_CLAMP_EN
    // Side data index k lines up with stage k; index NSTG-2 feeds the output stage.
    logic signed [31:0] r_zp  [NSTG-1];
    logic signed [31:0] r_min [NSTG-1];
    logic signed [31:0] r_max [NSTG-1];

    // Carry zero-point and clamp bounds alongside their beat.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_zp[0]  <= bus.out_zero_point;
            r_min[0] <= bus.act_min;
            r_max[0] <= bus.act_max;
            for (int k = 1; k < NSTG - 1; k++) begin
                r_zp[k]  <= r_zp[k-1];
                r_min[k] <= r_min[k-1];
                r_max[k] <= r_max[k-1];
            end
        end
    end
`else
    logic w_unused_side;
    assign w_unused_side = ^{bus.out_zero_point, bus.act_min, bus.act_max};
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam int unsigned QI = (PER_CHANNEL != 0) ? g : 0;

        logic signed [31:0] w_x, w_q, w_xs;
        logic signed [7:0]  w_s;
        logic [4:0]         w_rs;

        assign w_x  = bus.in_data[32*g +: 32];
        assign w_q  = bus.multiplier[32*QI +: 32];
        assign w_s  = bus.shift[8*QI +: 8];
        // Positive shift pre-scales x (wrapping); non-positive becomes a rounding right shift.
        assign w_xs = (w_s > 8'sd0) ? (w_x << w_s[4:0]) : w_x;
        assign w_rs = (w_s > 8'sd0) ? 5'd0 : (5'd0 - w_s[4:0]);

        logic signed [31:0] r_s0_xs, r_s0_q;
        logic [4:0]         r_s0_rs;

        // S0: capture pre-shifted operand, multiplier and right-shift amount.
        always_ff @(posedge clk) begin
            if (w_adv) begin
                r_s0_xs <= w_xs;
                r_s0_q  <= w_q;
                r_s0_rs <= w_rs;
            end
        end

        logic signed [63:0] r_mul_p   [MUL_STAGES];
        logic [4:0]         r_mul_rs  [MUL_STAGES];
        logic               r_mul_sat [MUL_STAGES];

        // Multiply in the first stage; later stages are delay registers for retiming.
        always_ff @(posedge clk) begin
            if (w_adv) begin
                r_mul_p[0]   <= 64'(r_s0_xs) * 64'(r_s0_q);
                r_mul_rs[0]  <= r_s0_rs;
                r_mul_sat[0] <= (r_s0_xs == MIN32) && (r_s0_q == MIN32);
                for (int k = 1; k < MUL_STAGES; k++) begin
                    r_mul_p[k]   <= r_mul_p[k-1];
                    r_mul_rs[k]  <= r_mul_rs[k-1];
                    r_mul_sat[k] <= r_mul_sat[k-1];
                end
            end
        end

        logic signed [63:0] w_p, w_sum, w_bias, w_quo;
        logic [31:0]        w_unused_quo;
        logic signed [31:0] r_h;
        logic [4:0]         r_h_rs;

        // SRDHM: round-half-away nudge, then divide by 2^31 truncating toward zero.
        assign w_p          = r_mul_p[MUL_STAGES-1];
        assign w_sum        = w_p + (w_p[63] ? NUDGE_NEG : NUDGE_POS);
        assign w_bias       = w_sum[63] ? (w_sum + 64'sh7FFF_FFFF) : w_sum;
        assign w_quo        = w_bias >>> 31;
        assign w_unused_quo = w_quo[63:32];

        // SRDHM register; the only overflowing product (-2^31 squared) saturates.
        always_ff @(posedge clk) begin
            if (w_adv) begin
                r_h    <= r_mul_sat[MUL_STAGES-1] ? MAX32 : w_quo[31:0];
                r_h_rs <= r_mul_rs[MUL_STAGES-1];
            end
        end

        logic [31:0]        w_mask, w_rem, w_thr;
        logic signed [31:0] w_r, r_r, w_o, r_out;

        // RDBPOT: arithmetic shift, round up when the remainder exceeds the threshold.
        assign w_mask = (32'd1 << r_h_rs) - 32'd1;
        assign w_rem  = r_h & w_mask;
        assign w_thr  = (w_mask >> 1) + {31'd0, r_h[31]};
        assign w_r    = (r_h >>> r_h_rs) + ((w_rem > w_thr) ? 32'sd1 : 32'sd0);

        // RDBPOT register.
        always_ff @(posedge clk) begin
            if (w_adv) begin
                r_r <= w_r;
            end
        end

`ifdef REQUANT_ZP_CLAMP_EN
        logic signed [32:0] w_zs;
        logic signed [31:0] w_sat;

        assign w_zs = 33'(r_r) + 33'(r_zp[NSTG-2]);

        // Saturating zero-point add followed by activation clamp.
        always_comb begin
            w_sat = w_zs[31:0];
            if (w_zs[32] != w_zs[31]) begin
                w_sat = w_zs[32] ? MIN32 : MAX32;
            end
            w_o = w_sat;
            if (w_sat < r_min[NSTG-2]) begin
                w_o = r_min[NSTG-2];
            end else if (w_sat > r_max[NSTG-2]) begin
                w_o = r_max[NSTG-2];
            end
        end
`else
        assign w_o = r_r;
`endif

        // Output register; cleared on reset and held while stalled.
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_out <= '0;
            end else if (w_adv) begin
                r_out <= w_o;
            end
        end

        assign w_out_lanes[g] = r_out;
    end
endmodule
